// File: rtl/tlul_host_bridge.sv
// tlul_host_bridge: req/gnt/rvalid host bus to TL-UL A/D; 1-cycle issue latency, D response registered 1 cycle.
// Back-pressure: gnt_o low while the A stage is stalled or in-flight limit is reached. Optional TLUL_HOST_SRC_CHECK_EN.
package tlul_pkg;
  localparam int TL_AIW = 8;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;
  localparam logic [3:0] MuBi4False     = 4'h9;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [31:0]       a_address;
    logic [3:0]        a_mask;
    logic [31:0]       a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [31:0]       d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // Hamming-style parity over the payload plus an overall parity bit.
  function automatic logic [6:0] intg_gen(input logic [63:0] din);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 64; j++) begin
        if ((((j + 1) >> i) & 1) != 0) p[i] = p[i] ^ din[j];
      end
    end
    p[6] = ^{din, p[5:0]};
    return p;
  endfunction

  function automatic tl_a_user_t tlul_cmd_intg_gen(input logic [3:0] instr_type,
                                                   input logic [31:0] addr,
                                                   input logic [2:0] opcode,
                                                   input logic [3:0] mask,
                                                   input logic [31:0] data);
    tl_a_user_t u;
    u.instr_type = instr_type;
    u.cmd_intg   = intg_gen({21'b0, instr_type, addr, opcode, mask});
    u.data_intg  = intg_gen({32'b0, data});
    return u;
  endfunction
endpackage

module tlul_host_bridge
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SrcBase        = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        rerr_o,
  output logic        rwrite_o,
  output logic        busy_o,
  output logic        err_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned SlotW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW:0]    MaxCnt   = (CntW + 1)'(MaxOutstanding);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(MaxOutstanding);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(MaxOutstanding - 1);

  logic             a_valid_q, a_valid_d;
  logic [2:0]       a_opcode_q, a_opcode_d;
  logic [31:0]      a_address_q, a_address_d;
  logic [3:0]       a_mask_q, a_mask_d;
  logic [31:0]      a_data_q, a_data_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rerr_q, rerr_d;
  logic             rwrite_q, rwrite_d;

  logic              a_pop, cnt_nz, d_acc;
  logic [CntW:0]     in_flight;
  logic [TL_AIW-1:0] a_source;

  assign a_pop     = a_valid_q & tl_i.a_ready;
  assign cnt_nz    = (cnt_q != '0);
  // Responses arriving with nothing outstanding are forwarded but not counted.
  assign d_acc     = tl_i.d_valid & cnt_nz;
  assign in_flight = {1'b0, cnt_q} + {{CntW{1'b0}}, a_valid_q};
  assign gnt_o     = req_i & (~a_valid_q | a_pop) & (in_flight < MaxCnt);
  assign a_source  = TL_AIW'(SrcBase) + TL_AIW'(slot_q);

  always_comb begin
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_address_d = a_address_q;
    a_mask_d    = a_mask_q;
    a_data_d    = a_data_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    rvalid_d    = tl_i.d_valid;
    rdata_d     = rdata_q;
    rerr_d      = rerr_q;
    rwrite_d    = rwrite_q;
    if (gnt_o) begin
      a_valid_d   = 1'b1;
      a_opcode_d  = !we_i ? Get : ((be_i == 4'hF) ? PutFullData : PutPartialData);
      a_address_d = {addr_i[31:2], 2'b00};
      a_mask_d    = be_i;
      a_data_d    = we_i ? wdata_i : 32'h0;
    end else if (a_pop) begin
      a_valid_d = 1'b0;
    end
    if (a_pop) slot_d = (slot_q == LastSlot) ? '0 : slot_q + SlotW'(1);
    if (a_pop && !d_acc && cnt_q != FullCnt) cnt_d = cnt_q + CntW'(1);
    else if (!a_pop && d_acc)                cnt_d = cnt_q - CntW'(1);
    if (tl_i.d_valid) begin
      rdata_d  = tl_i.d_data;
      rerr_d   = tl_i.d_error;
      rwrite_d = (tl_i.d_opcode == AccessAck);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= Get;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      slot_q      <= '0;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rerr_q      <= 1'b0;
      rwrite_q    <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_opcode_q  <= a_opcode_d;
      a_address_q <= a_address_d;
      a_mask_q    <= a_mask_d;
      a_data_q    <= a_data_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rerr_q      <= rerr_d;
      rwrite_q    <= rwrite_d;
    end
  end

`ifdef TLUL_HOST_SRC_CHECK_EN
  logic [TL_AIW-1:0] src_fifo_q [MaxOutstanding];
  logic [SlotW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic              err_q, err_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    err_d = err_q | (tl_i.d_valid & (~cnt_nz | (tl_i.d_source != src_fifo_q[rd_q])));
    if (a_pop) wr_d = (wr_q == LastSlot) ? '0 : wr_q + SlotW'(1);
    if (d_acc) rd_d = (rd_q == LastSlot) ? '0 : rd_q + SlotW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (a_pop) src_fifo_q[wr_q] <= a_source;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

  logic unused_sigs;
  assign unused_sigs = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};
`else
  assign err_o = 1'b0;

  logic unused_sigs;
  assign unused_sigs = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user,
                         tl_i.d_source};
`endif

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rerr_o   = rerr_q;
  assign rwrite_o = rwrite_q;
  assign busy_o   = a_valid_q | cnt_nz;

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid_q;
    tl_o.a_opcode  = a_opcode_q;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = a_source;
    tl_o.a_address = a_address_q;
    tl_o.a_mask    = a_mask_q;
    tl_o.a_data    = a_data_q;
    tl_o.a_user    = tlul_cmd_intg_gen(MuBi4False, a_address_q, a_opcode_q, a_mask_q, a_data_q);
    tl_o.d_ready   = 1'b1;
  end
endmodule

// File: tb/tb_tlul_host_bridge.sv
// Directed bench for tlul_host_bridge (MaxOutstanding=2, SrcBase=0): vector table plus multi-cycle sequences.
module tb_tlul_host_bridge;
  import tlul_pkg::*;

`ifdef TLUL_HOST_SRC_CHECK_EN
  localparam logic SrcChk = 1'b1;
`else
  localparam logic SrcChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        gnt;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = 4'hF;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rerr;
  logic        rwrite;
  logic        busy;
  logic        err;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  int total = 0;
  int bad   = 0;

  tlul_host_bridge #(.MaxOutstanding(2), .SrcBase(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata), .rerr_o(rerr),
    .rwrite_o(rwrite), .busy_o(busy), .err_o(err), .tl_o(tl_o), .tl_i(tl_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds d_valid for one posedge and returns at the next negedge.
  task automatic d_rsp(input logic [7:0] src, input logic [2:0] op, input logic [31:0] data,
                       input logic derr);
    tl_i.d_valid  = 1'b1;
    tl_i.d_source = src;
    tl_i.d_opcode = op;
    tl_i.d_data   = data;
    tl_i.d_error  = derr;
    @(negedge clk);
    tl_i.d_valid  = 1'b0;
    tl_i.d_error  = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] d_data;
    logic        d_err;
    logic [2:0]  x_op;
    logic [31:0] x_addr;
    logic [3:0]  x_mask;
    logic [31:0] x_data;
    logic [7:0]  x_src;
    logic        x_rwrite;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b0, 32'h1000_0004, 32'hAAAA_AAAA, 4'hF, 32'hDEAD_BEEF, 1'b0,
                3'h4, 32'h1000_0004, 4'hF, 32'h0000_0000, 8'd0, 1'b0};
    vecs[1] = '{1'b1, 32'h2000_0013, 32'h1234_5678, 4'h3, 32'h0000_0000, 1'b0,
                3'h1, 32'h2000_0010, 4'h3, 32'h1234_5678, 8'd1, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b1,
                3'h0, 32'h0000_00FC, 4'hF, 32'hCAFE_F00D, 8'd0, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h5555_5555, 4'h8, 32'h0123_4567, 1'b0,
                3'h4, 32'hFFFF_FFFC, 4'h8, 32'h0000_0000, 8'd1, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h4, 32'h0000_0000, 1'b0,
                3'h1, 32'h0000_0008, 4'h4, 32'hFFFF_FFFF, 8'd0, 1'b1};

    tl_i = '0;
    tl_i.a_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_valid", tl_o.a_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rerr", rerr, 1'b0);
    chk("rst_rwrite", rwrite, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_src", tl_o.a_source, 8'd0);
    rst_n = 1'b1;

    // Single transactions from the vector table
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req = 1'b1; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata; be = vecs[i].be;
      #1 chk($sformatf("v%0d_gnt", i), gnt, 1'b1);
      @(negedge clk);
      req = 1'b0;
      chk($sformatf("v%0d_a_valid", i), tl_o.a_valid, 1'b1);
      chk($sformatf("v%0d_opcode", i), tl_o.a_opcode, vecs[i].x_op);
      chk($sformatf("v%0d_addr", i), tl_o.a_address, vecs[i].x_addr);
      chk($sformatf("v%0d_mask", i), tl_o.a_mask, vecs[i].x_mask);
      chk($sformatf("v%0d_data", i), tl_o.a_data, vecs[i].x_data);
      chk($sformatf("v%0d_src", i), tl_o.a_source, vecs[i].x_src);
      chk($sformatf("v%0d_size_param", i), {tl_o.a_size, tl_o.a_param}, 5'b10_000);
      chk($sformatf("v%0d_instr_type", i), tl_o.a_user.instr_type, 4'h9);
      chk($sformatf("v%0d_busy_a", i), busy, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_popped", i), tl_o.a_valid, 1'b0);
      chk($sformatf("v%0d_busy_out", i), busy, 1'b1);
      chk($sformatf("v%0d_d_ready", i), tl_o.d_ready, 1'b1);
      d_rsp(vecs[i].x_src, vecs[i].we ? AccessAck : AccessAckData, vecs[i].d_data, vecs[i].d_err);
      chk($sformatf("v%0d_rvalid", i), rvalid, 1'b1);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].d_data);
      chk($sformatf("v%0d_rwrite", i), rwrite, vecs[i].x_rwrite);
      chk($sformatf("v%0d_rerr", i), rerr, vecs[i].d_err);
      chk($sformatf("v%0d_idle", i), busy, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_rvalid_pulse", i), rvalid, 1'b0);
      chk($sformatf("v%0d_rdata_hold", i), rdata, vecs[i].d_data);
    end
    chk("err_clean", err, 1'b0);

    // Outstanding limit with D stalled: two grants, third held off until a D accept
    do_reset();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_0100; be = 4'hF;
    #1 chk("lim_g1", gnt, 1'b1);
    @(negedge clk);
    #1 chk("lim_g2", gnt, 1'b1);
    chk("lim_src0", tl_o.a_source, 8'd0);
    @(negedge clk);
    #1 chk("lim_g3_blocked", gnt, 1'b0);
    chk("lim_src1", tl_o.a_source, 8'd1);
    chk("lim_a_valid2", tl_o.a_valid, 1'b1);
    @(negedge clk);
    #1 chk("lim_full_gnt", gnt, 1'b0);
    chk("lim_full_a_valid", tl_o.a_valid, 1'b0);
    chk("lim_full_busy", busy, 1'b1);
    @(negedge clk);
    #1 chk("lim_still_full", gnt, 1'b0);
    d_rsp(8'd0, AccessAckData, 32'h0000_0011, 1'b0);
    #1 chk("lim_gnt_after_d", gnt, 1'b1);
    chk("lim_rvalid", rvalid, 1'b1);
    @(negedge clk);
    req = 1'b0;
    chk("lim_a_valid3", tl_o.a_valid, 1'b1);
    chk("lim_src_wrap", tl_o.a_source, 8'd0);
    d_rsp(8'd1, AccessAckData, 32'h0000_0022, 1'b0);
    chk("simul_pop_acc_a", tl_o.a_valid, 1'b0);
    chk("simul_pop_acc_busy", busy, 1'b1);
    chk("simul_rdata", rdata, 32'h0000_0022);
    d_rsp(8'd0, AccessAckData, 32'h0000_0033, 1'b0);
    chk("lim_drained", busy, 1'b0);
    chk("lim_err_in_order", err, 1'b0);
    d_rsp(8'd5, AccessAck, 32'h0000_0077, 1'b0);
    chk("stray_rvalid", rvalid, 1'b1);
    chk("stray_rdata", rdata, 32'h0000_0077);
    chk("stray_no_underflow", busy, 1'b0);
    chk("stray_err", err, SrcChk);

    // Backpressure: a_ready low for 5 cycles, then issue
    do_reset();
    tl_i.a_ready = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0000_0040; wdata = 32'h55AA_55AA; be = 4'hF;
    #1 chk("bp_gnt", gnt, 1'b1);
    @(negedge clk);
    we = 1'b0; addr = 32'h0000_0080; wdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("bp%0d_a_valid", k), tl_o.a_valid, 1'b1);
      chk($sformatf("bp%0d_addr", k), tl_o.a_address, 32'h0000_0040);
      chk($sformatf("bp%0d_data", k), tl_o.a_data, 32'h55AA_55AA);
      chk($sformatf("bp%0d_op", k), tl_o.a_opcode, 3'h0);
      chk($sformatf("bp%0d_no_gnt", k), gnt, 1'b0);
    end
    @(negedge clk);
    chk("bp_still_valid", tl_o.a_valid, 1'b1);
    tl_i.a_ready = 1'b1;
    #1 chk("bp_gnt2", gnt, 1'b1);
    @(negedge clk);
    req = 1'b0;
    chk("bp_second_addr", tl_o.a_address, 32'h0000_0080);
    chk("bp_second_op", tl_o.a_opcode, 3'h4);
    chk("bp_second_src", tl_o.a_source, 8'd1);
    @(negedge clk);
    d_rsp(8'd0, AccessAck, 32'h0, 1'b0);
    chk("bp_rwrite", rwrite, 1'b1);
    d_rsp(8'd1, AccessAckData, 32'h0000_00BB, 1'b0);
    chk("bp_rwrite2", rwrite, 1'b0);
    chk("bp_drained", busy, 1'b0);

    // Reset mid-transaction, then a late response
    do_reset();
    tl_i.a_ready = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_0200; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    chk("mid_a_valid", tl_o.a_valid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tl_i.a_ready = 1'b1;
    chk("mid_rst_a_valid", tl_o.a_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    d_rsp(8'd0, AccessAckData, 32'h0000_0099, 1'b0);
    chk("late_rvalid", rvalid, 1'b1);
    chk("late_busy", busy, 1'b0);
    chk("late_err", err, SrcChk);

`ifdef TLUL_HOST_SRC_CHECK_EN
    do_reset();
    chk("sc_err_cleared", err, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_0300; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    d_rsp(8'd1, AccessAckData, 32'h0000_00AB, 1'b0);
    chk("sc_err_set", err, 1'b1);
    chk("sc_forwarded", rdata, 32'h0000_00AB);
    @(negedge clk);
    @(negedge clk);
    chk("sc_err_sticky", err, 1'b1);
    do_reset();
    chk("sc_err_reset", err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
